syn_i2s_rx: RTL and testbench

SYN_I2S_RX -- requirements
Module: syn_i2s_rx

---
 rtl/syn_i2s_rx.sv | 144 ++++++++++++++
 tb/tb_syn_i2s_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/syn_i2s_rx.sv
// syn_i2s_rx: I2S receiver that assembles left/right words into PCM frames.
//   clk, rst_n      system clock, asynchronous active-low reset
//   adc_bclk/lrc/dat codec bit clock, word select (0=L, 1=R) and serial data
//   cfg_en, cfg_bps  receiver enable, sample width (0 = 16 bit, 1 = 32 bit)
//   pcm_data         {lchnnl, rchnnl}, each PCM_DATA_W wide
//   pcm_valid/ready  output handshake; ovrflw pulses when a frame is dropped
module syn_i2s_rx #(
    parameter int PCM_DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    adc_bclk,
    input  logic                    adc_lrc,
    input  logic                    adc_dat,
    input  logic                    cfg_en,
    input  logic                    cfg_bps,
    output logic [2*PCM_DATA_W-1:0] pcm_data,
    output logic                    pcm_valid,
    input  logic                    pcm_ready,
    output logic                    ovrflw
);
    typedef enum logic {BPS_16, BPS_32} bps_t;
    typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} state_t;

    state_t                  state, state_nxt;
    bps_t                    bps_l;
    logic                    bclk_m, bclk_s, bclk_d;
    logic                    lrc_m, lrc_s, lrc_p;
    logic                    dat_m, dat_s;
    logic                    bclk_rise, lrc_fall, lrc_rise;
    logic                    start, store_l, done;
    logic [31:0]             sh, lword;
    logic [5:0]              cnt, n;
    logic [4:0]              idx;
    logic [2*PCM_DATA_W-1:0] frm;
    logic                    frm_v;

    function automatic logic [PCM_DATA_W-1:0] ext(input logic [31:0] w, input bps_t b);
        if (b == BPS_32)
            ext = PCM_DATA_W'(w);
        else
            ext = {{(PCM_DATA_W-16){w[15]}}, w[15:0]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {bclk_m, bclk_s, bclk_d} <= '0;
            {lrc_m, lrc_s, lrc_p}    <= '0;
            {dat_m, dat_s}           <= '0;
        end else begin
            {bclk_m, bclk_s, bclk_d} <= {adc_bclk, bclk_m, bclk_s};
            {lrc_m, lrc_s}           <= {adc_lrc, lrc_m};
            {dat_m, dat_s}           <= {adc_dat, dat_m};
            if (bclk_rise)
                lrc_p <= lrc_s;
        end
    end

    assign bclk_rise = bclk_s & ~bclk_d;
    assign lrc_fall  = bclk_rise & lrc_p & ~lrc_s;
    assign lrc_rise  = bclk_rise & ~lrc_p & lrc_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        store_l   = 1'b0;
        done      = 1'b0;
        if (!cfg_en)
            state_nxt = IDLE;
        else
            case (state)
                IDLE:  state_nxt = SYNC;
                SYNC:  if (lrc_fall) begin
                           state_nxt = LEFT;
                           start     = 1'b1;
                       end
                LEFT:  if (lrc_rise) begin
                           state_nxt = RIGHT;
                           store_l   = 1'b1;
                       end
                RIGHT: if (lrc_fall) begin
                           state_nxt = LEFT;
                           done      = 1'b1;
                       end
                default: state_nxt = IDLE;
            endcase
    end

    // Bits land MSB-first at position N-1-cnt, so a short word stays
    // MSB-aligned with zeroed LSBs and bits past N are simply not taken.
    assign n   = (bps_l == BPS_32) ? 6'd32 : 6'd16;
    assign idx = ((bps_l == BPS_32) ? 5'd31 : 5'd15) - cnt[4:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh    <= '0;
            cnt   <= '0;
            bps_l <= BPS_16;
            lword <= '0;
            frm   <= '0;
            frm_v <= 1'b0;
        end else begin
            frm_v <= done;
            if (start || done)
                bps_l <= bps_t'(cfg_bps);
            if (store_l)
                lword <= sh;
            if (done)
                frm <= {ext(lword, bps_l), ext(sh, bps_l)};
            // The bit sampled on an lrc transition belongs to the previous
            // word and is dropped; the new word starts from an empty register.
            if (start || store_l || done) begin
                sh  <= '0;
                cnt <= '0;
            end else if (bclk_rise && (state == LEFT || state == RIGHT) && cnt < n) begin
                sh[idx] <= dat_s;
                cnt     <= cnt + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
            ovrflw    <= 1'b0;
        end else begin
            if (frm_v && (!pcm_valid || pcm_ready)) begin
                pcm_data  <= frm;
                pcm_valid <= 1'b1;
            end else if (pcm_valid && pcm_ready) begin
                pcm_valid <= 1'b0;
            end
            ovrflw <= frm_v && pcm_valid && !pcm_ready;
        end
    end
endmodule

// File: tb/tb_syn_i2s_rx.sv
// tb_syn_i2s_rx: randomized I2S frames checked against a word-level model.
module tb_syn_i2s_rx;
    localparam int W = 32;

    logic           clk = 0, rst_n = 0;
    logic           adc_bclk = 0, adc_lrc = 0, adc_dat = 0;
    logic           cfg_en = 0, cfg_bps = 0, pcm_ready = 1;
    logic [2*W-1:0] pcm_data;
    logic           pcm_valid, ovrflw;
    int             total = 0, bad = 0, ovf_cnt = 0;
    logic [63:0]    got[$], exp_q[$];

    always #5 clk = ~clk;

    syn_i2s_rx #(.PCM_DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .adc_bclk(adc_bclk), .adc_lrc(adc_lrc),
        .adc_dat(adc_dat), .cfg_en(cfg_en), .cfg_bps(cfg_bps),
        .pcm_data(pcm_data), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
        .ovrflw(ovrflw)
    );

    // Frames accepted by the consumer and overflow pulses are logged here.
    always @(negedge clk) begin
        #1;
        if (rst_n && pcm_valid && pcm_ready) got.push_back(pcm_data);
        if (rst_n && ovrflw) ovf_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Expected channel value: the first k bits of an N-bit word, zero padded,
    // then widened (16-bit samples are sign-extended).
    function automatic logic [31:0] exp_word(input logic [31:0] w, input int n, input int k);
        logic [31:0] m;
        m = (n == 16) ? (w & 32'hFFFF) : w;
        if (k < n) m = m & ~((32'h1 << (n - k)) - 32'h1);
        return (n == 16) ? {{16{m[15]}}, m[15:0]} : m;
    endfunction

    task automatic bit_slot(input logic l, input logic d);
        adc_bclk = 0; adc_lrc = l; adc_dat = d;
        repeat (4) @(negedge clk);
        adc_bclk = 1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_word(input logic l, input logic [31:0] w, input int n, input int k);
        bit_slot(l, 1'($urandom));
        for (int i = 0; i < k; i++) bit_slot(l, (i < n) ? w[n-1-i] : 1'($urandom));
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n,
                              input int k, output logic [63:0] e);
        send_word(0, l, n, k);
        send_word(1, r, n, k);
        e = {exp_word(l, n, k), exp_word(r, n, k)};
    endtask

    task automatic close_slot();
        adc_bclk = 0; adc_lrc = 0; adc_dat = 1'($urandom);
        repeat (4) @(negedge clk);
        adc_bclk = 1;
    endtask

    task automatic close_frame();
        close_slot();
        repeat (12) @(negedge clk);
    endtask

    task automatic restart(input logic bps);
        cfg_en = 0;
        @(negedge clk);
        cfg_en = 1; cfg_bps = bps;
        bit_slot(1, 0);
        bit_slot(1, 0);
    endtask

    task automatic check_frames(input string tag);
        chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk(tag, got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [63:0] e, e2;
        int          o0;
        int          ks32[3] = '{32, 35, 20};
        int          ks16[3] = '{16, 19, 9};

        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(pcm_valid), 0);
        chk("rst_data", pcm_data, 0);
        chk("rst_ovf", 64'(ovrflw), 0);
        rst_n = 1;

        restart(1);
        send_frame(32'h80000001, 32'h7FFFFFFE, 32, 32, e);
        close_slot();
        repeat (3) @(posedge clk);
        #1 chk("lat_early", 64'(pcm_valid), 0);
        @(posedge clk);
        #1 chk("lat_valid", 64'(pcm_valid), 1);
        chk("bps32_fixed", pcm_data, 64'h80000001_7FFFFFFE);
        exp_q.push_back(e);
        repeat (12) @(negedge clk);
        check_frames("bps32");

        restart(1);
        foreach (ks32[i]) begin
            send_frame($urandom, $urandom, 32, ks32[i], e);
            exp_q.push_back(e);
        end
        close_frame();
        check_frames("rand32");

        restart(0);
        send_frame(32'h8001, 32'h1234, 16, 16, e);
        exp_q.push_back(e);
        foreach (ks16[i]) begin
            send_frame($urandom, $urandom, 16, ks16[i], e);
            exp_q.push_back(e);
        end
        close_frame();
        chk("bps16_fixed", got[0], 64'hFFFF8001_00001234);
        check_frames("rand16");

        restart(1);
        send_frame(32'hABCDEF00, $urandom, 32, 24, e);
        exp_q.push_back(e);
        close_frame();
        chk("short24", 64'(got[0][63:32]), 64'hABCDEF00);
        check_frames("short");

        restart(0);
        pcm_ready = 0;
        o0 = ovf_cnt;
        send_frame($urandom, $urandom, 16, 16, e);
        send_frame($urandom, $urandom, 16, 16, e2);
        close_frame();
        chk("ovf_hold", pcm_data, e);
        chk("ovf_valid", 64'(pcm_valid), 1);
        chk("ovf_pulses", 64'(ovf_cnt - o0), 1);
        pcm_ready = 1;
        @(posedge clk);
        #1 chk("ovf_drain", 64'(pcm_valid), 0);
        @(negedge clk);
        exp_q.push_back(e);
        check_frames("ovf");

        cfg_en = 0; cfg_bps = 0;
        bit_slot(1, 0);
        bit_slot(1, 0);
        send_word(0, $urandom, 16, 16);
        fork
            send_word(1, $urandom, 16, 16);
            begin repeat (60) @(negedge clk); cfg_en = 1; end
        join
        send_frame($urandom, $urandom, 16, 16, e);
        exp_q.push_back(e);
        close_frame();
        check_frames("en_mid");

        restart(0);
        send_word(0, $urandom, 16, 16);
        fork
            send_word(1, $urandom, 16, 16);
            begin repeat (60) @(negedge clk); cfg_en = 0; end
        join
        close_frame();
        chk("en_off_valid", 64'(pcm_valid), 0);
        check_frames("en_off");

        restart(0);
        pcm_ready = 0;
        send_frame($urandom, $urandom, 16, 16, e);
        fork
            send_word(0, $urandom, 16, 16);
            begin
                repeat (60) @(negedge clk);
                chk("pre_rst_valid", 64'(pcm_valid), 1);
                rst_n = 0;
                #1;
                chk("mid_rst_valid", 64'(pcm_valid), 0);
                chk("mid_rst_data", pcm_data, 0);
                chk("mid_rst_ovf", 64'(ovrflw), 0);
                @(negedge clk);
                rst_n = 1;
            end
        join
        send_word(1, $urandom, 16, 16);
        pcm_ready = 1;
        send_frame($urandom, $urandom, 16, 16, e);
        exp_q.push_back(e);
        close_frame();
        check_frames("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
